if_stage: RTL

//  Instruction fetch front end: producer side of the decoder's inst/inst_ready interface.

---
 rtl/if_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Purpose: instruction fetch front end; one outstanding imem request, fetched words queued for id_stage.
// Latency: best case one instruction every 2 cycles; response push to inst_ready is 1 cycle.
// Backpressure: a request is only issued when the fetch queue has room for its response.
module if_stage #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_ready,
  output logic [63:0] inst_pc
);

  localparam int            PW      = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FQ_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic [63:0]   pc;
  logic [63:0]   req_pc;
  logic [63:0]   hold_addr;
  logic          hold_vld;
  logic          kill;
  logic [31:0]   fq_inst [FQ_DEPTH];
  logic [63:0]   fq_pc   [FQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          grant, push, pop;
  logic [63:0]   redirect_aligned;
  logic          redirect_lsb_unused;

  assign redirect_aligned    = {redirect_pc[63:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Request only with queue credit; a request caught by a redirect keeps its old address until granted.
  always_comb begin
    imem_req  = (state == S_REQ) && (count < DEPTH_C);
    imem_addr = hold_vld ? hold_addr : pc;
  end

  assign grant = imem_req & imem_gnt;
  // A redirect flushes the queue, so it also suppresses any push or pop in the same cycle.
  assign push  = (state == S_WAIT) & imem_rvalid & ~kill & ~redirect_valid;
  assign pop   = inst_ready & id_ready & ~redirect_valid;

  // Next-state logic; redirects never alter the request/response handshake sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (grant) state_nxt = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, PC, held-request and kill tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= PC_RESET;
      req_pc    <= '0;
      hold_vld  <= 1'b0;
      hold_addr <= '0;
      kill      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) req_pc <= imem_addr;

      // With a held request pc already holds the redirect target, so no +4 on its grant.
      if (redirect_valid)
        pc <= redirect_aligned;
      else if (grant && !hold_vld)
        pc <= pc + 64'd4;

      if (redirect_valid && imem_req && !imem_gnt) begin
        hold_vld  <= 1'b1;
        hold_addr <= imem_addr;
      end else if (grant) begin
        hold_vld  <= 1'b0;
      end

      // An in-flight or already-presented request is marked for discard; a response
      // landing in the redirect cycle is simply not pushed.
      if (redirect_valid) begin
        if ((state == S_WAIT) && imem_rvalid)
          kill <= 1'b0;
        else if ((state == S_WAIT) || imem_req)
          kill <= 1'b1;
      end else if ((state == S_WAIT) && imem_rvalid) begin
        kill <= 1'b0;
      end
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Queue storage; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_inst[wr_ptr] <= imem_rdata;
      fq_pc[wr_ptr]   <= req_pc;
    end
  end

  // Head-of-queue presentation with a nop and zero PC when empty.
  always_comb begin
    inst_ready = (count != '0);
    inst       = inst_ready ? fq_inst[rd_ptr] : 32'h0000_0013;
    inst_pc    = inst_ready ? fq_pc[rd_ptr]   : 64'd0;
  end

endmodule
